// File: rtl/mem_access.sv
// rtl/mem_access.sv - load/store unit bridging the execute stage to an AXI4-Lite master port
// One request in flight at a time; the upstream pipeline is held via mem_stall until DONE.
module mem_access (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_rd_en,
  input  logic        mem_wr_en,
  input  logic        mem_except,
  input  logic [63:0] addr_mem_rd,
  input  logic [63:0] addr_mem_wr,
  input  logic [63:0] data_mem_wr,
  input  logic [7:0]  strb_mem_wr,
  input  logic [2:0]  load_code,
  output logic [63:0] araddr,
  output logic        arvalid,
  output logic        rready,
  output logic [63:0] awaddr,
  output logic        awvalid,
  output logic [63:0] wdata,
  output logic [7:0]  wstrb,
  output logic        wvalid,
  output logic        bready,
  input  logic        arready,
  input  logic [63:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  input  logic        awready,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        mem_stall,
  output logic [63:0] ld_data,
  output logic        ld_valid,
  output logic        bus_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t      state;
  logic [2:0]  ld_code_q;
  logic        aw_done;
  logic        w_done;

  logic        req_rd;
  logic        req_wr;
  logic        aw_fire;
  logic        w_fire;
  logic        aw_all;
  logic        w_all;
  logic [63:0] ld_ext;

  assign req_rd  = mem_rd_en & ~mem_except;
  assign req_wr  = mem_wr_en & ~mem_except;
  assign aw_fire = awvalid & awready;
  assign w_fire  = wvalid & wready;
  assign aw_all  = aw_done | aw_fire;
  assign w_all   = w_done | w_fire;

  assign mem_stall = (state == RD_ADDR) || (state == RD_DATA) ||
                     (state == WR_REQ)  || (state == WR_RESP) ||
                     ((state == IDLE) && (req_rd || req_wr));

  always_comb begin
    ld_ext = rdata;
    case (ld_code_q)
      3'b000:  ld_ext = {{56{rdata[7]}},  rdata[7:0]};
      3'b001:  ld_ext = {{48{rdata[15]}}, rdata[15:0]};
      3'b010:  ld_ext = {{32{rdata[31]}}, rdata[31:0]};
      3'b100:  ld_ext = {56'd0, rdata[7:0]};
      3'b101:  ld_ext = {48'd0, rdata[15:0]};
      3'b110:  ld_ext = {32'd0, rdata[31:0]};
      default: ld_ext = rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ld_code_q <= 3'b111;
      araddr    <= 64'd0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      awaddr    <= 64'd0;
      awvalid   <= 1'b0;
      wdata     <= 64'd0;
      wstrb     <= 8'd0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      ld_data   <= 64'd0;
      ld_valid  <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A store wins over a simultaneous load; the load is simply dropped.
          if (req_wr) begin
            awaddr  <= addr_mem_wr;
            wdata   <= data_mem_wr;
            wstrb   <= strb_mem_wr;
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= WR_REQ;
          end else if (req_rd) begin
            araddr    <= addr_mem_rd;
            ld_code_q <= load_code;
            arvalid   <= 1'b1;
            state     <= RD_ADDR;
          end
        end
        RD_ADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (rvalid) begin
            rready <= 1'b0;
            if (rresp == 2'b00) begin
              ld_data  <= ld_ext;
              ld_valid <= 1'b1;
            end else begin
              bus_err  <= 1'b1;
            end
            state <= DONE;
          end
        end
        WR_REQ: begin
          if (aw_fire) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_fire) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
          end
          if (aw_all && w_all) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            bready  <= 1'b1;
            state   <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (bvalid) begin
            bready  <= 1'b0;
            bus_err <= (bresp != 2'b00);
            state   <= DONE;
          end
        end
        DONE: begin
          ld_valid <= 1'b0;
          bus_err  <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - directed self-checking bench for mem_access
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_rd_en = 1'b0, mem_wr_en = 1'b0, mem_except = 1'b0;
  logic [63:0] addr_mem_rd = '0, addr_mem_wr = '0, data_mem_wr = '0;
  logic [7:0]  strb_mem_wr = '0;
  logic [2:0]  load_code = 3'b111;
  logic [63:0] araddr, awaddr, wdata, ld_data;
  logic        arvalid, rready, awvalid, wvalid, bready;
  logic [7:0]  wstrb;
  logic        arready = 1'b0, rvalid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [63:0] rdata = '0;
  logic [1:0]  rresp = 2'b00, bresp = 2'b00;
  logic        mem_stall, ld_valid, bus_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_access dut (
    .clk(clk), .rst_n(rst_n),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_except(mem_except),
    .addr_mem_rd(addr_mem_rd), .addr_mem_wr(addr_mem_wr),
    .data_mem_wr(data_mem_wr), .strb_mem_wr(strb_mem_wr), .load_code(load_code),
    .araddr(araddr), .arvalid(arvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .wdata(wdata), .wstrb(wstrb),
    .wvalid(wvalid), .bready(bready),
    .arready(arready), .rdata(rdata), .rresp(rresp), .rvalid(rvalid),
    .awready(awready), .wready(wready), .bresp(bresp), .bvalid(bvalid),
    .mem_stall(mem_stall), .ld_data(ld_data), .ld_valid(ld_valid), .bus_err(bus_err)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Zero-wait load: request presented in cycle T, slave always ready.
  task automatic zw_load(input string nm, input logic [2:0] code, input logic [63:0] addr,
                         input logic [63:0] rd, input logic [1:0] resp,
                         input logic [63:0] exp_data, input logic exp_ok);
    mem_rd_en = 1'b1; load_code = code; addr_mem_rd = addr;
    arready = 1'b1; rvalid = 1'b1; rdata = rd; rresp = resp;
    #1 check_val({nm, "_stall_T"}, mem_stall, 1);
    tick;
    mem_rd_en = 1'b0; load_code = 3'b111;
    check_val({nm, "_arvalid_T1"}, arvalid, 1);
    check_val({nm, "_araddr_T1"}, araddr, addr);
    check_val({nm, "_rready_T1"}, rready, 0);
    tick;
    check_val({nm, "_arvalid_T2"}, arvalid, 0);
    check_val({nm, "_rready_T2"}, rready, 1);
    check_val({nm, "_stall_T2"}, mem_stall, 1);
    tick;
    check_val({nm, "_ld_valid_T3"}, ld_valid, exp_ok);
    check_val({nm, "_bus_err_T3"}, bus_err, !exp_ok);
    check_val({nm, "_ld_data_T3"}, ld_data, exp_data);
    check_val({nm, "_stall_T3"}, mem_stall, 0);
    check_val({nm, "_rready_T3"}, rready, 0);
    arready = 1'b0; rvalid = 1'b0; rresp = 2'b00;
    tick;
    check_val({nm, "_ld_valid_T4"}, ld_valid, 0);
    check_val({nm, "_bus_err_T4"}, bus_err, 0);
    check_val({nm, "_ld_data_T4"}, ld_data, exp_data);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_arvalid", arvalid, 0);
    check_val("rst_rready", rready, 0);
    check_val("rst_awvalid", awvalid, 0);
    check_val("rst_wvalid", wvalid, 0);
    check_val("rst_bready", bready, 0);
    check_val("rst_ld_valid", ld_valid, 0);
    check_val("rst_bus_err", bus_err, 0);
    check_val("rst_ld_data", ld_data, 0);
    check_val("rst_araddr", araddr, 0);
    check_val("rst_wstrb", wstrb, 0);
    rst_n = 1'b1;
    tick;
    check_val("idle_no_req_stall", mem_stall, 0);
    check_val("idle_no_req_arvalid", arvalid, 0);

    zw_load("lb", 3'b000, 64'h1000, 64'h0000_0000_0000_00F0, 2'b00, 64'hFFFF_FFFF_FFFF_FFF0, 1'b1);
    zw_load("lwu", 3'b110, 64'h2008, 64'h1234_5678_8000_0001, 2'b00, 64'h0000_0000_8000_0001, 1'b1);
    zw_load("lw", 3'b010, 64'h2010, 64'h1234_5678_8000_0001, 2'b00, 64'hFFFF_FFFF_8000_0001, 1'b1);
    zw_load("lhu", 3'b101, 64'h2018, 64'h0000_0000_0000_9ABC, 2'b00, 64'h0000_0000_0000_9ABC, 1'b1);
    zw_load("ld", 3'b011, 64'h2020, 64'h1234_5678_8000_0001, 2'b00, 64'h1234_5678_8000_0001, 1'b1);
    // Error response leaves the previous load result in place.
    zw_load("lh_err", 3'b001, 64'h2028, 64'h0000_0000_0000_FFFF, 2'b10, 64'h1234_5678_8000_0001, 1'b0);

    // Store with awready at T+1 and wready delayed until T+4.
    mem_wr_en = 1'b1; addr_mem_wr = 64'h3000; data_mem_wr = 64'hDEAD_BEEF_CAFE_F00D; strb_mem_wr = 8'hFF;
    #1 check_val("sd_stall_T", mem_stall, 1);
    tick;
    mem_wr_en = 1'b0;
    check_val("sd_awvalid_T1", awvalid, 1);
    check_val("sd_wvalid_T1", wvalid, 1);
    check_val("sd_awaddr_T1", awaddr, 64'h3000);
    check_val("sd_wdata_T1", wdata, 64'hDEAD_BEEF_CAFE_F00D);
    check_val("sd_wstrb_T1", wstrb, 8'hFF);
    awready = 1'b1;
    tick;
    awready = 1'b0;
    check_val("sd_awvalid_T2", awvalid, 0);
    check_val("sd_wvalid_T2", wvalid, 1);
    check_val("sd_stall_T2", mem_stall, 1);
    tick;
    check_val("sd_wvalid_T3", wvalid, 1);
    check_val("sd_bready_T3", bready, 0);
    tick;
    check_val("sd_wvalid_T4", wvalid, 1);
    wready = 1'b1;
    tick;
    wready = 1'b0;
    check_val("sd_wvalid_T5", wvalid, 0);
    check_val("sd_bready_T5", bready, 1);
    check_val("sd_stall_T5", mem_stall, 1);
    bvalid = 1'b1; bresp = 2'b00;
    tick;
    bvalid = 1'b0;
    check_val("sd_stall_T6", mem_stall, 0);
    check_val("sd_bready_T6", bready, 0);
    check_val("sd_bus_err_T6", bus_err, 0);
    check_val("sd_ld_valid_T6", ld_valid, 0);
    tick;

    // Store and load together: store wins.
    mem_wr_en = 1'b1; mem_rd_en = 1'b1; addr_mem_wr = 64'h4000; addr_mem_rd = 64'h5000;
    strb_mem_wr = 8'h0F; awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
    tick;
    mem_wr_en = 1'b0; mem_rd_en = 1'b0;
    check_val("both_awvalid", awvalid, 1);
    check_val("both_arvalid", arvalid, 0);
    check_val("both_wstrb", wstrb, 8'h0F);
    tick;
    check_val("both_bready", bready, 1);
    tick;
    check_val("both_done_stall", mem_stall, 0);
    check_val("both_done_ld_valid", ld_valid, 0);
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    tick;
    check_val("both_idle_arvalid", arvalid, 0);

    // Excepted load never reaches the bus.
    mem_rd_en = 1'b1; mem_except = 1'b1; load_code = 3'b011; addr_mem_rd = 64'h6000;
    arready = 1'b1; rvalid = 1'b1;
    #1 check_val("exc_stall", mem_stall, 0);
    tick;
    check_val("exc_arvalid", arvalid, 0);
    tick;
    tick;
    check_val("exc_ld_valid", ld_valid, 0);
    check_val("exc_rready", rready, 0);
    mem_rd_en = 1'b0; mem_except = 1'b0; arready = 1'b0; rvalid = 1'b0;
    tick;

    // Reset while waiting in RD_DATA.
    mem_rd_en = 1'b1; load_code = 3'b011; addr_mem_rd = 64'h7000; arready = 1'b1;
    rdata = 64'h1111_2222_3333_4444; rresp = 2'b00;
    tick;
    mem_rd_en = 1'b0;
    tick;
    arready = 1'b0;
    check_val("rst_mid_rready_pre", rready, 1);
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_mid_arvalid", arvalid, 0);
    check_val("rst_mid_rready", rready, 0);
    check_val("rst_mid_stall", mem_stall, 0);
    tick;
    rst_n = 1'b1;
    rvalid = 1'b1;
    tick;
    check_val("rst_post_ld_valid1", ld_valid, 0);
    check_val("rst_post_arvalid", arvalid, 0);
    tick;
    check_val("rst_post_ld_valid2", ld_valid, 0);
    check_val("rst_post_stall", mem_stall, 0);
    rvalid = 1'b0;
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
